// File: rtl/opser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : opser_pkg
// Brief   : Shared types, default parameters and helpers for operand_serializer.
// Revision: 1.0 - initial release
// ============================================================================
package opser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } opser_state_t;

    localparam int WIDTH   = 8;
    localparam int SLOTS   = 3;
    localparam int MIN_GAP = 1;

    function automatic logic [3:0] popcount(input logic [7:0] mask);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, mask[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opser_slot_pick.sv
`default_nettype none
// ============================================================================
// Module  : opser_slot_pick
// Brief   : Lowest-set-bit priority encoder with a single-bit-remaining flag.
// Revision: 1.0 - initial release
// ============================================================================
module opser_slot_pick #(
    parameter int SLOTS = 3,
    parameter int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0] mask,
    output logic [IW-1:0]    idx,
    output logic             is_last
);

    // Descending scan so the lowest set bit is the final assignment.
    always_comb begin
        idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IW'(i);
            end
        end
        is_last = (mask != '0) && ((mask & (mask - SLOTS'(1))) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/operand_serializer.sv
`default_nettype none
// ============================================================================
// Module  : operand_serializer
// Brief   : Emits the valid bytes of a parallel frame one per cycle as put/value.
// Revision: 1.0 - initial release
// ============================================================================
module operand_serializer #(
    parameter int WIDTH   = opser_pkg::WIDTH,
    parameter int SLOTS   = opser_pkg::SLOTS,
    parameter int MIN_GAP = opser_pkg::MIN_GAP,
    parameter int CW      = $clog2(SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [SLOTS*WIDTH-1:0] din,
    input  logic [SLOTS-1:0]       din_valid,
    input  logic                   abort,
    output logic                   ready,
    output logic                   put,
    output logic [WIDTH-1:0]       value,
    output logic [CW-1:0]          count,
    output logic                   done,
    output logic                   aborted,
    output logic                   empty_err
);
    import opser_pkg::*;

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    opser_state_t             r_state;
    logic [SLOTS*WIDTH-1:0]   r_frame;
    logic [SLOTS-1:0]         r_pending;
    logic                     r_last;
    logic [GW-1:0]            r_gap;

    logic [SLOTS-1:0]         w_mask;
    logic [SLOTS-1:0]         w_rest;
    logic [IW-1:0]            w_idx;
    logic                     w_is_last;
    logic [WIDTH-1:0]         w_data;

    // The first byte is picked straight from din so it appears one cycle after load.
    assign w_mask = (r_state == IDLE) ? din_valid : r_pending;
    assign w_rest = w_mask & ~(SLOTS'(1) << w_idx);
    assign w_data = (r_state == IDLE) ? din[int'(w_idx)*WIDTH +: WIDTH]
                                      : r_frame[int'(w_idx)*WIDTH +: WIDTH];

    opser_slot_pick #(
        .SLOTS (SLOTS),
        .IW    (IW)
    ) u_pick (
        .mask    (w_mask),
        .idx     (w_idx),
        .is_last (w_is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_pending <= '0;
            r_last    <= 1'b0;
            r_gap     <= '0;
            ready     <= 1'b1;
            put       <= 1'b0;
            value     <= '0;
            count     <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            empty_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            aborted   <= 1'b0;
            empty_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load && ready) begin
                        if (din_valid != '0) begin
                            r_state   <= SEND;
                            ready     <= 1'b0;
                            r_frame   <= din;
                            r_pending <= w_rest;
                            r_last    <= w_is_last;
                            put       <= 1'b1;
                            value     <= w_data;
                            count     <= CW'(1);
                        end else begin
                            empty_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (abort || r_last) begin
                        r_state   <= GAP;
                        r_pending <= '0;
                        r_last    <= 1'b0;
                        r_gap     <= GW'(MIN_GAP - 1);
                        put       <= 1'b0;
                        value     <= '0;
                        aborted   <= abort;
                        done      <= !abort;
                    end else begin
                        r_pending <= w_rest;
                        r_last    <= w_is_last;
                        value     <= w_data;
                        if (count != CW'(SLOTS)) begin
                            count <= count + CW'(1);
                        end
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        r_state <= IDLE;
                        ready   <= 1'b1;
                        count   <= '0;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                    put     <= 1'b0;
                    value   <= '0;
                    count   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_serializer
// Brief   : Directed and randomized bench for operand_serializer with a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_operand_serializer;
    import opser_pkg::*;

    localparam int W  = WIDTH;
    localparam int S  = SLOTS;
    localparam int G  = MIN_GAP;
    localparam int CW = $clog2(S + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic             abort = 1'b0;
    logic [S*W-1:0]   din = '0;
    logic [S-1:0]     din_valid = '0;
    logic             ready, put, done, aborted, empty_err;
    logic [W-1:0]     value;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_serializer #(.WIDTH(W), .SLOTS(S), .MIN_GAP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (din),
        .din_valid (din_valid),
        .abort     (abort),
        .ready     (ready),
        .put       (put),
        .value     (value),
        .count     (count),
        .done      (done),
        .aborted   (aborted),
        .empty_err (empty_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is the list of valid bytes in slot order, shown one per cycle,
    // followed by G quiet cycles before the block is ready again.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_frame[$];
    bit           m_show = 0;
    int           m_gap = 0;
    logic [W-1:0] m_val = '0;
    int           m_cnt = 0;
    bit           m_done = 0, m_abt = 0, m_emp = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_show = 0; m_gap = 0; m_val = '0; m_cnt = 0;
            m_done = 0; m_abt = 0; m_emp = 0;
        end else begin
            m_done = 0; m_abt = 0; m_emp = 0;
            if (m_show) begin
                if (abort) begin
                    m_show = 0; m_abt = 1; m_gap = G; m_q.delete(); m_val = '0;
                end else if (m_q.size() == 0) begin
                    m_show = 0; m_done = 1; m_gap = G; m_val = '0;
                end else begin
                    m_val = m_q.pop_front();
                    m_cnt = (m_cnt < S) ? m_cnt + 1 : S;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) m_cnt = 0;
            end else if (load) begin
                m_frame.delete();
                for (int i = 0; i < S; i++)
                    if (din_valid[i]) m_frame.push_back(din[i*W +: W]);
                if (m_frame.size() == 0) begin
                    m_emp = 1;
                end else begin
                    m_q = m_frame;
                    m_val = m_q.pop_front();
                    m_show = 1;
                    m_cnt = 1;
                end
            end
        end
    end

    // Downstream accumulator: stores each put byte into r0..r(S-1).
    logic [W-1:0] acc[S];
    int           acc_n = 0;

    always @(negedge rst_n) acc_n = 0;

    always @(negedge clk) begin
        chk("ready",     32'(ready),     32'(!m_show && m_gap == 0));
        chk("put",       32'(put),       32'(m_show));
        chk("value",     32'(value),     32'(m_val));
        chk("count",     32'(count),     32'(m_cnt));
        chk("done",      32'(done),      32'(m_done));
        chk("aborted",   32'(aborted),   32'(m_abt));
        chk("empty_err", 32'(empty_err), 32'(m_emp));
        if (put) begin
            if (acc_n < S) acc[acc_n] = value;
            acc_n++;
        end
        if (aborted) acc_n = 0;
        if (done) begin
            chk("acc_len", 32'(acc_n), 32'(m_frame.size()));
            for (int i = 0; i < acc_n && i < S && i < m_frame.size(); i++)
                chk("acc_reg", 32'(acc[i]), 32'(m_frame[i]));
            acc_n = 0;
        end
    end

    task automatic offer(input logic [S*W-1:0] d, input logic [S-1:0] v);
        @(negedge clk);
        load = 1'b1; din = d; din_valid = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50 && !(ready && !put); k++) @(negedge clk);
        chk("idle_timeout", 32'(ready && !put), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_put",   32'(put),   32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;

        // Full frame
        offer(24'h332211, 3'b111);
        chk("t1_b0", 32'(value), 32'h11);
        @(negedge clk); chk("t1_b1", 32'(value), 32'h22);
        @(negedge clk); chk("t1_b2", 32'(value), 32'h33); chk("t1_cnt", 32'(count), 32'd3);
        @(negedge clk); chk("t1_done", 32'(done), 32'd1); chk("t1_put", 32'(put), 32'd0);
        repeat (G) @(negedge clk);
        chk("t1_ready", 32'(ready), 32'd1);

        // Sparse frame
        offer(24'hC0EEA0, 3'b101);
        chk("t2_b0", 32'(value), 32'hA0);
        @(negedge clk); chk("t2_b1", 32'(value), 32'hC0); chk("t2_put", 32'(put), 32'd1);
        @(negedge clk); chk("t2_done", 32'(done), 32'd1); chk("t2_cnt", 32'(count), 32'd2);
        wait_idle();

        // Empty load
        offer(24'h123456, 3'b000);
        chk("t3_err", 32'(empty_err), 32'd1);
        chk("t3_put", 32'(put), 32'd0);
        chk("t3_ready", 32'(ready), 32'd1);

        // Abort after the first byte
        offer(24'h030201, 3'b111);
        chk("t4_b0", 32'(value), 32'h01);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_put", 32'(put), 32'd0);
        chk("t4_aborted", 32'(aborted), 32'd1);
        chk("t4_done", 32'(done), 32'd0);
        wait_idle();

        // Back-to-back with load held high
        begin
            int  gapc;
            bit  seen_b;
            gapc = 0; seen_b = 0;
            @(negedge clk);
            load = 1'b1; din = 24'h939291; din_valid = 3'b111;
            @(negedge clk);
            din = 24'h005544; din_valid = 3'b011;
            for (int k = 0; k < 30 && !seen_b; k++) begin
                @(negedge clk);
                if (!put && !ready) gapc++;
                if (put && value == 8'h44) seen_b = 1;
            end
            load = 1'b0;
            chk("t5_seen_b", 32'(seen_b), 32'd1);
            chk("t5_gap", 32'(gapc), 32'(G));
            @(negedge clk); chk("t5_b1", 32'(value), 32'h55);
            wait_idle();
        end

        // Reset in the middle of a frame
        offer(24'h666564, 3'b111);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_put", 32'(put), 32'd0);
        chk("t6_value", 32'(value), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready", 32'(ready), 32'd1);
        chk("t6_pulses", 32'({done, aborted, empty_err}), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                load = 1'b0; abort = 1'b0;
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else begin
                load = 1'($urandom_range(0, 1));
                for (int i = 0; i < S; i++) din[i*W +: W] = W'($urandom);
                din_valid = S'($urandom);
                abort = ($urandom_range(0, 9) == 0);
            end
        end
        load = 1'b0; abort = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
